// File: rtl/multi_edge_watcher_if.sv
// -----------------------------------------------------------------------------
// multi_edge_watcher_if
// Groups the per-channel signals of the multi-channel edge watcher.
//   signal   : raw asynchronous inputs, bit i = channel i
//   edge_sel : per-channel event mode, bits [2i+1:2i] (00 none, 01 rise,
//              10 fall, 11 both)
//   clr      : per-channel sticky-event clear (level-sensitive)
//   level    : debounced level
//   pos/neg  : one-cycle pulses on debounced rise/fall
//   evt      : sticky event flags
//   any_evt  : OR of all evt bits
// master = the block driving the inputs, slave = the watcher itself.
// -----------------------------------------------------------------------------
interface multi_edge_watcher_if #(
  parameter int CH = 4
);
  logic [CH-1:0]   signal;
  logic [2*CH-1:0] edge_sel;
  logic [CH-1:0]   clr;
  logic [CH-1:0]   level;
  logic [CH-1:0]   pos;
  logic [CH-1:0]   neg;
  logic [CH-1:0]   evt;
  logic            any_evt;

  modport master (
    output signal, edge_sel, clr,
    input  level, pos, neg, evt, any_evt
  );

  modport slave (
    input  signal, edge_sel, clr,
    output level, pos, neg, evt, any_evt
  );
endinterface

// File: rtl/multi_edge_watcher.sv
// -----------------------------------------------------------------------------
// multi_edge_watcher
// Per channel: SYNC-stage synchroniser, stable-count debounce filter,
// registered rise/fall pulses and a sticky, mode-selectable event flag.
// Ports:
//   clk : system clock, all state on rising edge
//   rst : asynchronous active-high reset
//   bus : multi_edge_watcher_if.slave (signal, edge_sel, clr in;
//         level, pos, neg, evt, any_evt out)
// Parameters: CH channels, SYNC synchroniser stages (>=2), DB_CYC cycles a
// new synchronised value must persist before level follows it (>=1).
// -----------------------------------------------------------------------------
module multi_edge_watcher #(
  parameter int CH     = 4,
  parameter int SYNC   = 2,
  parameter int DB_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  multi_edge_watcher_if.slave   bus
);
  localparam int            CW       = $clog2(DB_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic [CH-1:0] sync_q [SYNC];
  logic [CH-1:0] sync_d [SYNC];
  logic [CW-1:0] cnt_q  [CH];
  logic [CW-1:0] cnt_d  [CH];
  logic [CH-1:0] level_q, level_d;
  logic [CH-1:0] pos_q, pos_d;
  logic [CH-1:0] neg_q, neg_d;
  logic [CH-1:0] evt_q, evt_d;
  logic [CH-1:0] s, rise, fall, set;

  assign s = sync_q[SYNC-1];

  // Synchroniser shift chain and debounce filter.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    level_d   = level_q;
    sync_d[0] = bus.signal;
    for (int k = 1; k < SYNC; k++) sync_d[k] = sync_q[k-1];
    for (int i = 0; i < CH; i++) begin
      // Agreement with level (including a return to it) restarts the count.
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) level_d[i] = s[i];
        else                      cnt_d[i]   = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edges are taken from the level about to be registered, so pos/neg/evt
  // update on the same clock edge as level itself.
  assign rise = level_d & ~level_q;
  assign fall = level_q & ~level_d;

  for (genvar i = 0; i < CH; i++) begin : g_set
    assign set[i] = (bus.edge_sel[2*i] & rise[i]) | (bus.edge_sel[2*i+1] & fall[i]);
  end

  assign pos_d = rise;
  assign neg_d = fall;
  // A set on the same edge as a clear wins, so no event is ever lost.
  assign evt_d = set | (evt_q & ~bus.clr);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the synchroniser chain and counter arrays are reset too; a stale
      // stage or partial count must not leak into the first filtered level.
      for (int k = 0; k < SYNC; k++) sync_q[k] <= '0;
      for (int i = 0; i < CH; i++)   cnt_q[i]  <= '0;
      level_q <= '0;
      pos_q   <= '0;
      neg_q   <= '0;
      evt_q   <= '0;
    end else begin
      for (int k = 0; k < SYNC; k++) sync_q[k] <= sync_d[k];
      for (int i = 0; i < CH; i++)   cnt_q[i]  <= cnt_d[i];
      level_q <= level_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      evt_q   <= evt_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.pos     = pos_q;
  assign bus.neg     = neg_q;
  assign bus.evt     = evt_q;
  assign bus.any_evt = |evt_q;
endmodule

// File: tb/tb_multi_edge_watcher.sv
// -----------------------------------------------------------------------------
// tb_multi_edge_watcher
// Directed testbench for multi_edge_watcher with default parameters
// (CH=4, SYNC=2, DB_CYC=4: level follows on edge 6 after an input change).
// Inputs change just after a falling edge; outputs are checked on falling
// edges, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_multi_edge_watcher;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;

  multi_edge_watcher_if #(.CH(4)) bus ();

  multi_edge_watcher #(.CH(4), .SYNC(2), .DB_CYC(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks every output; any_evt expectation is the OR of the expected evt.
  task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] p,
                           input logic [3:0] n, input logic [3:0] e);
    check({tag, ".level"},   {4'h0, bus.level},   {4'h0, lvl});
    check({tag, ".pos"},     {4'h0, bus.pos},     {4'h0, p});
    check({tag, ".neg"},     {4'h0, bus.neg},     {4'h0, n});
    check({tag, ".evt"},     {4'h0, bus.evt},     {4'h0, e});
    check({tag, ".any_evt"}, {7'h0, bus.any_evt}, {7'h0, |e});
  endtask

  // Advance n rising edges, returning on the falling edge after the last.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;

    // ---- Reset state ----
    rst          = 1'b1;
    bus.signal   = 4'h0;
    bus.edge_sel = 8'h00;
    bus.clr      = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 4'h0, 4'h0, 4'h0, 4'h0);

    // ---- Release with all inputs high: level rises on edge 6 ----
    rst          = 1'b0;
    bus.signal   = 4'hF;
    bus.edge_sel = 8'h55;
    tick(5);
    check_all("rel_e5", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("rel_e6", 4'hF, 4'hF, 4'h0, 4'hF);

    // ---- Asynchronous reset mid-cycle clears everything at once ----
    #2 rst = 1'b1;
    #1 check_all("async_rst", 4'h0, 4'h0, 4'h0, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    check_all("rerel_e5", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("rerel_e6", 4'hF, 4'hF, 4'h0, 4'hF);
    tick(1);
    check_all("rerel_e7", 4'hF, 4'h0, 4'h0, 4'hF);

    // Clear all, then drop all inputs with mode 00: neg pulses, nothing recorded.
    bus.clr = 4'hF;
    tick(1);
    check_all("clr_all", 4'hF, 4'h0, 4'h0, 4'h0);
    bus.clr      = 4'h0;
    bus.edge_sel = 8'h00;
    bus.signal   = 4'h0;
    tick(6);
    check_all("fall_mode00", 4'h0, 4'h0, 4'hF, 4'h0);
    tick(1);

    // ---- Clean rise on ch0, mode rise ----
    bus.edge_sel = 8'h01;
    bus.signal   = 4'h1;
    tick(5);
    check_all("rise0_e5", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("rise0_e6", 4'h1, 4'h1, 4'h0, 4'h1);
    tick(1);
    check_all("rise0_e7", 4'h1, 4'h0, 4'h0, 4'h1);
    tick(3);
    check_all("rise0_hold", 4'h1, 4'h0, 4'h0, 4'h1);
    bus.clr = 4'h1;
    tick(1);
    check_all("rise0_clr", 4'h1, 4'h0, 4'h0, 4'h0);
    bus.clr = 4'h0;

    // ---- Glitch reject on ch1: 3-cycle high pulse ----
    bus.edge_sel = 8'h05;
    bus.signal   = 4'h3;
    tick(3);
    bus.signal   = 4'h1;
    tick(8);
    check_all("glitch", 4'h1, 4'h0, 4'h0, 4'h0);

    // 4-cycle high pulse is accepted on edge 6; its fall follows 4 edges later.
    bus.signal = 4'h3;
    tick(4);
    bus.signal = 4'h1;
    tick(1);
    check_all("pulse4_e5", 4'h1, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("pulse4_e6", 4'h3, 4'h2, 4'h0, 4'h2);
    tick(4);
    check_all("pulse4_fall", 4'h1, 4'h0, 4'h2, 4'h2);
    bus.clr = 4'h2;
    tick(1);
    check_all("pulse4_clr", 4'h1, 4'h0, 4'h0, 4'h0);
    bus.clr = 4'h0;

    // ---- Modes on ch2: fall-only, then none ----
    bus.edge_sel = 8'h20;
    bus.signal   = 4'h5;
    tick(6);
    check_all("m10_rise", 4'h5, 4'h4, 4'h0, 4'h0);
    bus.signal = 4'h1;
    tick(6);
    check_all("m10_fall", 4'h1, 4'h0, 4'h4, 4'h4);
    bus.edge_sel = 8'h00;
    bus.clr      = 4'h4;
    tick(1);
    check_all("m10_clr", 4'h1, 4'h0, 4'h0, 4'h0);
    bus.clr    = 4'h0;
    bus.signal = 4'h5;
    tick(6);
    check_all("m00_rise", 4'h5, 4'h4, 4'h0, 4'h0);
    bus.signal = 4'h1;
    tick(6);
    check_all("m00_fall", 4'h1, 4'h0, 4'h4, 4'h0);

    // ---- Set/clear collision on ch3, mode both ----
    bus.edge_sel = 8'hC0;
    bus.clr      = 4'h8;
    bus.signal   = 4'h9;
    tick(6);
    check_all("coll_set", 4'h9, 4'h8, 4'h0, 4'h8);
    tick(1);
    check_all("coll_clr", 4'h9, 4'h0, 4'h0, 4'h0);
    bus.clr = 4'h0;

    // ---- Multi-channel: all toggle together, each with its own mode ----
    // ch0 fall, ch1 rise, ch2 none, ch3 both.
    bus.edge_sel = 8'hC6;
    bus.signal   = 4'h6;
    tick(5);
    check_all("multi_e5", 4'h9, 4'h0, 4'h0, 4'h0);
    tick(1);
    check_all("multi_e6", 4'h6, 4'h6, 4'h9, 4'hB);
    tick(1);
    check_all("multi_e7", 4'h6, 4'h0, 4'h0, 4'hB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
